bios_loader: RTL and testbench

Write-side companion to the synchronous BIOS ROM/RAM: it accepts the HPS `ioctl` download byte stream and packs the bytes little-endian into `DW`-bit words. It issues those words on a single-port memory write interface with a ready handshake, and asserts `bios_loaded` once a complete image has been committed. It sits between the MiSTer `hps_io` download port and the BIOS storage, which then serves CPU reads.

---
 rtl/bios_loader.sv | 127 ++++++++++++
 tb/tb_bios_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_loader.sv
// bios_loader: packs the HPS ioctl byte stream little-endian into DW-bit
// words and writes them to BIOS storage over a ready handshake.
module bios_loader #(
  parameter int DW    = 16,
  parameter int AW    = 13,
  parameter int INDEX = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic          mem_ready,
  output logic          bios_loaded,
  output logic          error
);

  localparam int BPW = DW / 8;
  localparam int L   = $clog2(BPW);
  localparam int LW  = (L > 0) ? L : 1;

  typedef enum logic [1:0] {
    IDLE, LOAD, FLUSH, DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] buffer;
  logic [AW-1:0] addr_q;
  logic          valid;

  logic          sel, start, entry;
  logic          strobe, range_bad, fault, take;
  logic          first, last, flush_go;
  logic [LW-1:0] lane;
  logic [LW+2:0] sh;
  logic [AW-1:0] word, addr_wr;
  logic [DW-1:0] buf_in, buf_wr;

  assign sel   = (ioctl_index == 8'(INDEX));
  assign start = ioctl_download && sel;
  assign entry = start && (state == IDLE || state == DONE);

  assign lane      = LW'(ioctl_addr & 25'(BPW - 1));
  assign word      = AW'(ioctl_addr >> L);
  assign range_bad = (ioctl_addr >> (L + AW)) != 25'd0;

  // A strobe while a write is still outstanding would overrun the buffer.
  assign strobe = (state == LOAD) && ioctl_wr && sel;
  assign fault  = strobe && (range_bad || mem_we);
  assign take   = strobe && !fault;

  assign first   = (lane == '0);
  assign last    = (lane == LW'(BPW - 1));
  assign sh      = {lane, 3'b000};
  assign buf_in  = first ? '0 : buffer;
  assign buf_wr  = (buf_in & ~(DW'(8'hFF) << sh))
                 | (DW'(ioctl_dout) << sh);
  assign addr_wr = first ? word : addr_q;

  assign flush_go = (state == FLUSH) && valid
                 && (!mem_we || mem_ready);

  assign ioctl_wait = mem_we;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (!ioctl_download) state_nx = FLUSH;
      FLUSH:   if (!valid && !mem_we) state_nx = DONE;
      DONE:    if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_we      <= 1'b0;
      mem_a       <= '0;
      mem_d       <= '0;
      buffer      <= '0;
      addr_q      <= '0;
      valid       <= 1'b0;
      error       <= 1'b0;
      bios_loaded <= 1'b0;
    end else begin
      bios_loaded <= (state_nx == DONE);
      if (mem_we && mem_ready) mem_we <= 1'b0;
      if (entry) begin
        buffer <= '0;
        valid  <= 1'b0;
        error  <= 1'b0;
      end else if (fault) begin
        error <= 1'b1;
      end else if (take && last) begin
        mem_we <= 1'b1;
        mem_a  <= addr_wr;
        mem_d  <= buf_wr;
        buffer <= '0;
        valid  <= 1'b0;
      end else if (take) begin
        buffer <= buf_wr;
        addr_q <= addr_wr;
        valid  <= valid || first;
      end else if (flush_go) begin
        mem_we <= 1'b1;
        mem_a  <= addr_q;
        mem_d  <= buffer;
        buffer <= '0;
        valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: directed bench for bios_loader (DW=16, AW=13).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_bios_loader;

  logic        clock;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_we;
  logic [12:0] mem_a;
  logic [15:0] mem_d;
  logic        mem_ready;
  logic        bios_loaded;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [28:0] wq[$];

  bios_loader #(.DW(16), .AW(13), .INDEX(0)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_we(mem_we),
    .mem_a(mem_a),
    .mem_d(mem_d),
    .mem_ready(mem_ready),
    .bios_loaded(bios_loaded),
    .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record each write that the next rising edge will accept.
  always @(negedge clock)
    if (reset_n && mem_we && mem_ready)
      wq.push_back({mem_a, mem_d});

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a,
                        input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] o;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    step();
    step();
    o = {ioctl_wait, mem_we, mem_a, mem_d, bios_loaded, error};
    vectors++;
    if (o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    reset_n = 1'b1;
    step();
    vectors++;
    if (bios_loaded !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_loaded: got %b want 0", bios_loaded);
    end
  endtask

  task automatic test_full_image();
    int bad;
    logic [28:0] exp;
    mem_ready = 1'b1;
    begin_dl(8'd0);
    wq.delete();
    strobe(25'd0, 8'h00);
    strobe(25'd1, 8'h01);
    vectors++;
    if ({mem_we, ioctl_wait, mem_a, mem_d} !==
        {1'b1, 1'b1, 13'd0, 16'h0100}) begin
      miscompares++;
      $display("FAIL first_word: got %b %b %h %h want 1 1 0 0100",
               mem_we, ioctl_wait, mem_a, mem_d);
    end
    step();
    vectors++;
    if ({mem_we, ioctl_wait} !== 2'b00) begin
      miscompares++;
      $display("FAIL wait_one_cycle: got %b%b want 00",
               mem_we, ioctl_wait);
    end
    for (int k = 1; k < 128; k++) begin
      strobe(25'(2 * k), 8'(2 * k));
      strobe(25'(2 * k + 1), 8'(2 * k + 1));
      step();
    end
    ioctl_download = 1'b0;
    step();
    vectors++;
    if (bios_loaded !== 1'b0) begin
      miscompares++;
      $display("FAIL full_loaded_early: got %b want 0", bios_loaded);
    end
    step();
    vectors++;
    if (bios_loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL full_loaded: got %b want 1", bios_loaded);
    end
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL full_error: got %b want 0", error);
    end
    vectors++;
    if (wq.size() !== 128) begin
      miscompares++;
      $display("FAIL full_count: got %0d want 128", wq.size());
    end
    bad = 0;
    for (int k = 0; k < 128 && k < wq.size(); k++) begin
      exp = {13'(k), 8'(2 * k + 1), 8'(2 * k)};
      if (wq[k] !== exp) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL full_data: got %0d bad words want 0", bad);
    end
    vectors++;
    if (wq.size() > 3 && wq[3] !== {13'd3, 16'h0706}) begin
      miscompares++;
      $display("FAIL full_word3: got %h want %h",
               wq[3], {13'd3, 16'h0706});
    end
  endtask

  task automatic test_backpressure();
    begin_dl(8'd0);
    vectors++;
    if (bios_loaded !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_clear: got %b want 0", bios_loaded);
    end
    mem_ready = 1'b0;
    wq.delete();
    strobe(25'd0, 8'h34);
    strobe(25'd1, 8'h12);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({mem_we, ioctl_wait, mem_a, mem_d} !==
          {1'b1, 1'b1, 13'd0, 16'h1234}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got %b %b %h %h want 1 1 0 1234",
                 c, mem_we, ioctl_wait, mem_a, mem_d);
      end
      if (c < 4) step();
    end
    mem_ready = 1'b1;
    step();
    vectors++;
    if ({mem_we, ioctl_wait} !== 2'b00) begin
      miscompares++;
      $display("FAIL bp_accept: got %b%b want 00", mem_we, ioctl_wait);
    end
    vectors++;
    if (wq.size() !== 1 || wq[0] !== {13'd0, 16'h1234}) begin
      miscompares++;
      $display("FAIL bp_write: got %0d writes want 1 of 0:1234",
               wq.size());
    end
    ioctl_download = 1'b0;
    step();
    step();
  endtask

  task automatic test_odd_length();
    begin_dl(8'd0);
    wq.delete();
    strobe(25'd0, 8'hAA);
    strobe(25'd1, 8'hBB);
    step();
    strobe(25'd2, 8'hCC);
    ioctl_download = 1'b0;
    step();
    step();
    vectors++;
    if ({mem_we, mem_a, mem_d, bios_loaded} !==
        {1'b1, 13'd1, 16'h00CC, 1'b0}) begin
      miscompares++;
      $display("FAIL odd_flush: got %b %h %h %b want 1 1 00cc 0",
               mem_we, mem_a, mem_d, bios_loaded);
    end
    step();
    vectors++;
    if ({mem_we, bios_loaded} !== 2'b00) begin
      miscompares++;
      $display("FAIL odd_accept: got %b%b want 00",
               mem_we, bios_loaded);
    end
    step();
    vectors++;
    if (bios_loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL odd_loaded: got %b want 1", bios_loaded);
    end
    vectors++;
    if (wq.size() !== 2 || wq[0] !== {13'd0, 16'hBBAA}
        || wq[1] !== {13'd1, 16'h00CC}) begin
      miscompares++;
      $display("FAIL odd_writes: got %0d writes want 0:bbaa 1:00cc",
               wq.size());
    end
  endtask

  task automatic test_range();
    begin_dl(8'd0);
    wq.delete();
    strobe(25'd16382, 8'h11);
    strobe(25'd16383, 8'h22);
    step();
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL range_top_ok: got %b want 0", error);
    end
    strobe(25'd16384, 8'h55);
    vectors++;
    if ({error, mem_we} !== 2'b10) begin
      miscompares++;
      $display("FAIL range_error: got %b%b want 10", error, mem_we);
    end
    ioctl_download = 1'b0;
    step();
    step();
    vectors++;
    if (wq.size() !== 1 || wq[0] !== {13'd8191, 16'h2211}) begin
      miscompares++;
      $display("FAIL range_writes: got %0d writes want 1fff:2211",
               wq.size());
    end
    vectors++;
    if ({bios_loaded, error} !== 2'b11) begin
      miscompares++;
      $display("FAIL range_done: got %b%b want 11", bios_loaded, error);
    end
  endtask

  task automatic test_index();
    wq.delete();
    begin_dl(8'd1);
    strobe(25'd0, 8'h99);
    strobe(25'd1, 8'h88);
    step();
    vectors++;
    if ({bios_loaded, error, mem_we} !== 3'b110) begin
      miscompares++;
      $display("FAIL index_ignored: got %b%b%b want 110",
               bios_loaded, error, mem_we);
    end
    vectors++;
    if (wq.size() !== 0) begin
      miscompares++;
      $display("FAIL index_writes: got %0d want 0", wq.size());
    end
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    step();
  endtask

  task automatic test_protocol();
    begin_dl(8'd0);
    vectors++;
    if ({bios_loaded, error} !== 2'b00) begin
      miscompares++;
      $display("FAIL entry_clear: got %b%b want 00", bios_loaded, error);
    end
    mem_ready = 1'b0;
    wq.delete();
    strobe(25'd0, 8'h01);
    strobe(25'd1, 8'h02);
    strobe(25'd2, 8'h03);
    vectors++;
    if ({error, mem_we, mem_a, mem_d} !==
        {1'b1, 1'b1, 13'd0, 16'h0201}) begin
      miscompares++;
      $display("FAIL wait_strobe: got %b %b %h %h want 1 1 0 0201",
               error, mem_we, mem_a, mem_d);
    end
    mem_ready = 1'b1;
    step();
    vectors++;
    if (wq.size() !== 1 || wq[0] !== {13'd0, 16'h0201}) begin
      miscompares++;
      $display("FAIL wait_write: got %0d writes want 0:0201",
               wq.size());
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] o;
    mem_ready = 1'b0;
    strobe(25'd4, 8'h44);
    strobe(25'd5, 8'h55);
    vectors++;
    if ({mem_we, mem_a, mem_d} !== {1'b1, 13'd2, 16'h5544}) begin
      miscompares++;
      $display("FAIL pre_reset: got %b %h %h want 1 2 5544",
               mem_we, mem_a, mem_d);
    end
    reset_n = 1'b0;
    #1;
    o = {ioctl_wait, mem_we, mem_a, mem_d, bios_loaded, error};
    vectors++;
    if (o !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", o);
    end
    ioctl_download = 1'b0;
    mem_ready = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    step();
    vectors++;
    if ({bios_loaded, mem_we} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b%b want 00",
               bios_loaded, mem_we);
    end
  endtask

  initial begin
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    mem_ready      = 1'b1;
    test_reset();
    test_full_image();
    test_backpressure();
    test_odd_length();
    test_range();
    test_index();
    test_protocol();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
